// File: rtl/seq_step_ctrl.sv
// Run controller for the 8-entry table walker: accepts a run command, paces one-cycle
// step pulses from a period down-counter and tracks the wrapped table index.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// RUN   | pacing steps; cnt counts down to the next step
// HOLD  | paused; cnt frozen until pause drops or stop arrives
// DONE  | run finished or aborted; issues the done pulse, then IDLE
module seq_step_ctrl #(
   parameter int IDX_W = 3,
   parameter int DIV_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_up,
   input  logic             cmd_cont,
   input  logic             cmd_home,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0] cmd_div,
   input  logic             pause,
   input  logic             stop,
   output logic             step_o,
   output logic             up_o,
   output logic [IDX_W-1:0] index_o,
   output logic             wrap_o,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             cont_q, cont_d;
   logic             up_q, up_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         cont_q  <= 1'b0;
         up_q    <= 1'b1;
         idx_q   <= '0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         cont_q  <= cont_d;
         up_q    <= up_d;
         idx_q   <= idx_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      rem_d   = rem_q;
      cont_d  = cont_q;
      up_d    = up_q;
      idx_d   = idx_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               up_d   = cmd_up;
               cnt_d  = cmd_div;
               div_d  = cmd_div;
               rem_d  = cmd_steps;
               cont_d = cmd_cont;
               if (cmd_home) idx_d = '0;
               if (!cmd_cont && (cmd_steps == '0)) state_d = S_DONE;
               else                                 state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_DONE;
            end else if (pause) begin
               state_d = S_HOLD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DIV_W'(1);
            end else begin
               step_d = 1'b1;
               cnt_d  = div_q;
               if (up_q) begin
                  idx_d  = idx_q + IDX_W'(1);
                  wrap_d = (idx_q == {IDX_W{1'b1}});
               end else begin
                  idx_d  = idx_q - IDX_W'(1);
                  wrap_d = (idx_q == '0);
               end
               // rem is only meaningful for counted runs; continuous runs end on stop
               if (!cont_q) begin
                  rem_d = rem_q - CNT_W'(1);
                  if (rem_q == CNT_W'(1)) state_d = S_DONE;
               end
            end
         end
         S_HOLD: begin
            if (stop)        state_d = S_DONE;
            else if (!pause) state_d = S_RUN;
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign step_o    = step_q;
   assign up_o      = up_q;
   assign index_o   = idx_q;
   assign wrap_o    = wrap_q;
   assign done      = done_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Bench for seq_step_ctrl: directed run scenarios with literal expectations, then a long
// randomized stream, all continuously compared against a cycle-level behavioural model.
module tb_seq_step_ctrl;
   localparam int IDX_W = 3;
   localparam int DIV_W = 16;
   localparam int CNT_W = 8;
   localparam int DEPTH = 1 << IDX_W;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_up = 1'b0;
   logic             cmd_cont = 1'b0;
   logic             cmd_home = 1'b0;
   logic [CNT_W-1:0] cmd_steps = '0;
   logic [DIV_W-1:0] cmd_div = '0;
   logic             pause = 1'b0;
   logic             stop = 1'b0;
   logic             step_o;
   logic             up_o;
   logic [IDX_W-1:0] index_o;
   logic             wrap_o;
   logic             busy;
   logic             done;

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   seq_step_ctrl #(.IDX_W(IDX_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_up(cmd_up), .cmd_cont(cmd_cont), .cmd_home(cmd_home),
      .cmd_steps(cmd_steps), .cmd_div(cmd_div), .pause(pause), .stop(stop),
      .step_o(step_o), .up_o(up_o), .index_o(index_o), .wrap_o(wrap_o),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a run is "active" (pacing), "held", or "ending" (done pending).
   bit m_active, m_held, m_ending;
   int m_wait, m_left, m_div, m_idx;
   bit m_cont, m_up, m_step, m_wrap, m_done;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 0; m_held = 0; m_ending = 0;
         m_wait = 0; m_left = 0; m_div = 0; m_idx = 0;
         m_cont = 0; m_up = 1; m_step = 0; m_wrap = 0; m_done = 0;
      end else begin
         m_step = 0; m_wrap = 0; m_done = 0;
         if (m_ending) begin
            m_done = 1;
            m_ending = 0;
         end else if (!m_active && !m_held) begin
            if (cmd_valid) begin
               m_up = cmd_up; m_cont = cmd_cont;
               m_wait = int'(cmd_div); m_div = int'(cmd_div); m_left = int'(cmd_steps);
               if (cmd_home) m_idx = 0;
               if (!cmd_cont && cmd_steps == 0) m_ending = 1;
               else                              m_active = 1;
            end
         end else if (stop) begin
            m_active = 0; m_held = 0; m_ending = 1;
         end else if (m_held) begin
            if (!pause) begin m_held = 0; m_active = 1; end
         end else if (pause) begin
            m_active = 0; m_held = 1;
         end else if (m_wait > 0) begin
            m_wait--;
         end else begin
            m_step = 1;
            m_wrap = m_up ? (m_idx == DEPTH - 1) : (m_idx == 0);
            m_idx  = (m_idx + (m_up ? 1 : DEPTH - 1)) % DEPTH;
            m_wait = m_div;
            if (!m_cont) begin
               m_left--;
               if (m_left == 0) begin m_active = 0; m_ending = 1; end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && cmp_en) begin
         chk("model step_o", 32'(step_o), 32'(m_step));
         chk("model wrap_o", 32'(wrap_o), 32'(m_wrap));
         chk("model done", 32'(done), 32'(m_done));
         chk("model up_o", 32'(up_o), 32'(m_up));
         chk("model index_o", 32'(index_o), 32'(m_idx));
         chk("model busy", 32'(busy), 32'(m_active | m_held | m_ending));
         chk("model cmd_ready", 32'(cmd_ready), 32'(!(m_active | m_held | m_ending)));
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input bit up, input bit cont, input bit home, input int steps, input int div);
      cmd_up = up; cmd_cont = cont; cmd_home = home;
      cmd_steps = CNT_W'(steps); cmd_div = DIV_W'(div);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      chk("reset index", 32'(index_o), 0);
      chk("reset up", 32'(up_o), 1);
      chk("reset ready", 32'(cmd_ready), 1);
      chk("reset step", 32'(step_o), 0);

      // up, counted: steps at edges 3,6,9; done at 10
      send(1, 0, 0, 3, 2);
      chk("t1 busy", 32'(busy), 1);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("t1 step", 32'(step_o), 32'(k == 3 || k == 6 || k == 9));
         chk("t1 index", 32'(index_o), (k < 3) ? 0 : (k < 6) ? 1 : (k < 9) ? 2 : 3);
         chk("t1 wrap", 32'(wrap_o), 0);
         chk("t1 done", 32'(done), 32'(k == 10));
      end
      chk("t1 ready", 32'(cmd_ready), 1);

      // down with home, div=0: 7 (wrap) then 6
      send(0, 0, 1, 2, 0);
      chk("t2 home", 32'(index_o), 0);
      tick();
      chk("t2 idx1", 32'(index_o), 7);
      chk("t2 wrap1", 32'(wrap_o), 1);
      chk("t2 step1", 32'(step_o), 1);
      tick();
      chk("t2 idx2", 32'(index_o), 6);
      chk("t2 wrap2", 32'(wrap_o), 0);
      tick();
      chk("t2 done", 32'(done), 1);
      chk("t2 up", 32'(up_o), 0);

      // zero-step counted run
      send(1, 0, 0, 0, 5);
      chk("t3 busy", 32'(busy), 1);
      tick();
      chk("t3 done", 32'(done), 1);
      chk("t3 step", 32'(step_o), 0);
      chk("t3 ready", 32'(cmd_ready), 1);
      chk("t3 index", 32'(index_o), 6);

      // continuous, pause 10 cycles mid-period, then stop
      send(1, 1, 0, 0, 3);
      for (int k = 1; k <= 22; k++) begin
         tick();
         chk("t4 step", 32'(step_o), 32'(k == 15 || k == 19));
         chk("t4 index", 32'(index_o), (k < 15) ? 6 : (k < 19) ? 7 : 0);
         chk("t4 wrap", 32'(wrap_o), 32'(k == 19));
         chk("t4 done", 32'(done), 32'(k == 22));
         if (k == 2)  pause = 1'b1;
         if (k == 12) pause = 1'b0;
         if (k == 20) stop = 1'b1;
         if (k == 21) stop = 1'b0;
      end

      // command during a run is ignored; then home before the first step
      send(1, 0, 0, 3, 1);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("t6 step", 32'(step_o), 32'(k == 2 || k == 4 || k == 6));
         chk("t6 index", 32'(index_o), (k < 2) ? 0 : (k < 4) ? 1 : (k < 6) ? 2 : 3);
         chk("t6 up", 32'(up_o), 1);
         chk("t6 done", 32'(done), 32'(k == 7));
         if (k == 1) begin
            cmd_valid = 1'b1; cmd_up = 1'b0; cmd_home = 1'b1;
            cmd_steps = '0; cmd_div = '0;
         end
         if (k == 3) cmd_valid = 1'b0;
      end
      send(1, 0, 1, 1, 2);
      chk("t6 home idx", 32'(index_o), 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("t6b step", 32'(step_o), 32'(k == 3));
         chk("t6b index", 32'(index_o), (k < 3) ? 0 : 1);
         chk("t6b done", 32'(done), 32'(k == 4));
      end

      // async reset mid-run at index 5
      send(0, 1, 1, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("t5 index", 32'(index_o), 8 - k);
      end
      #2 rst = 1'b1;
      #1;
      chk("t5 rst index", 32'(index_o), 0);
      chk("t5 rst up", 32'(up_o), 1);
      chk("t5 rst busy", 32'(busy), 0);
      chk("t5 rst step", 32'(step_o), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("t5 no done", 32'(done), 0);
         chk("t5 idle", 32'(busy), 0);
      end

      // randomized stream
      for (int c = 0; c < 3000; c++) begin
         cmd_valid = ($urandom % 3) == 0;
         cmd_up    = 1'($urandom % 2);
         cmd_cont  = ($urandom % 6) == 0;
         cmd_home  = ($urandom % 4) == 0;
         cmd_steps = CNT_W'($urandom_range(0, 6));
         cmd_div   = DIV_W'($urandom_range(0, 4));
         if (pause) pause = ($urandom % 3) != 0;
         else       pause = ($urandom % 12) == 0;
         stop = ($urandom % 40) == 0;
         tick();
      end
      cmd_valid = 1'b0; pause = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
